otter_fetch_unit: RTL

Instruction fetch front end for the OTTER core: owns the program counter and issues reads to the synchronous instruction memory. Buffers returned words in a small FIFO and presents them to the control-unit decoder over a valid/ready handshake, with the opcode, funct3 and funct7 fields pre-sliced. Taken branches and jumps redirect fetch through a one-cycle flush.

---
 rtl/otter_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/otter_fetch_unit.sv | 90 +++++++++
 3 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER front-end types: decoder opcode enum, fetch FSM states, NOP and reset vector.
// Pure declarations, no logic, no flow control.
package otter_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_t;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;
  localparam int          FETCH_ENTRY_W     = 64;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries; head visible the cycle after push, clr beats push/pop.
// Backpressure: push is ignored when full, pop when empty; the producer sizes requests to avoid both.
module fetch_fifo
  import otter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = FETCH_ENTRY_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (!do_push && do_pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/otter_fetch_unit.sv
// OTTER fetch: PC + imem reads, 2-cycle read-to-valid latency, redirect flushes via one FLUSH cycle.
// Backpressure: ir_ready stalls the head; reads only issue while buffered + in-flight words fit the FIFO.
module otter_fetch_unit
  import otter_pkg::*;
#(
  parameter logic [31:0] RESET_VEC  = DEFAULT_RESET_VEC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_rd_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic [6:0]  cu_opcode,
  output logic [2:0]  func,
  output logic [6:0]  check_func
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d, req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   occupancy;
  logic          drop, fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [63:0]   fifo_head;

  always_comb begin
    occupancy  = (state_q == FLUSH) ? 32'd0 : 32'(fifo_count) + 32'(inflight_q);
    imem_rd_en = occupancy < 32'(FIFO_DEPTH);
    // Responses landing in a redirect or FLUSH cycle belong to the abandoned stream.
    drop       = redirect_valid || (state_q == FLUSH);
    fifo_push  = inflight_q && !drop && !fifo_full;
    fifo_pop   = ir_valid && ir_ready;
    state_d    = redirect_valid ? FLUSH : RUN;
    inflight_d = imem_rd_en && !redirect_valid;
    req_pc_d   = imem_rd_en ? pc_q : req_pc_q;
    if (redirect_valid)  pc_d = redirect_pc & ~32'h3;
    else if (imem_rd_en) pc_d = pc_q + 32'd4;
    else                 pc_d = pc_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= RUN;
      pc_q       <= RESET_VEC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (64)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .clr   (redirect_valid),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({req_pc_q, imem_rdata}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    imem_addr  = pc_q;
    ir_valid   = !fifo_empty;
    ir         = ir_valid ? fifo_head[31:0]  : NOP_INSTR;
    ir_pc      = ir_valid ? fifo_head[63:32] : 32'h0;
    cu_opcode  = ir[6:0];
    func       = ir[14:12];
    check_func = ir[31:25];
  end

endmodule
